// File: rtl/layer_ctrl_pkg.sv
// Shared types and helpers for the fully-connected layer sequencing controller.
package layer_ctrl_pkg;

    // Controller phases: gather the input vector, walk one row of addresses,
    // let the last memory read land, latch the accumulator, present the row.
    typedef enum logic [2:0] {
        LOAD  = 3'd0,
        ADDR  = 3'd1,
        DRAIN = 3'd2,
        LATCH = 3'd3,
        OUT   = 3'd4
    } state_t;

    localparam int STALL_W = 32;

    // Address width for a memory of n entries; a single-entry memory still
    // gets a one-bit address so no port collapses to zero width.
    function automatic int addr_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/layer_ctrl_if.sv
// Control bundle between layer_ctrl and its datapath / stream neighbours.
// master: the controller side; slave: the datapath and stream side.
interface layer_ctrl_if
    import layer_ctrl_pkg::*;
#(
    parameter int M = 4,
    parameter int N = 4
);
    localparam int AW_X = addr_width(N);
    localparam int AW_W = addr_width(M * N);

    logic                s_valid;
    logic                s_ready;
    logic                m_ready;
    logic                m_valid;
    logic                m_last;
    logic                x_wr_en;
    logic [AW_X-1:0]     x_addr;
    logic [AW_W-1:0]     w_addr;
    logic                mac_clr;
    logic                mac_en;
    logic                y_load;
    logic [STALL_W-1:0]  stall_cnt;

    modport master (
        input  s_valid, m_ready,
        output s_ready, m_valid, m_last, x_wr_en, x_addr, w_addr,
               mac_clr, mac_en, y_load, stall_cnt
    );

    modport slave (
        output s_valid, m_ready,
        input  s_ready, m_valid, m_last, x_wr_en, x_addr, w_addr,
               mac_clr, mac_en, y_load, stall_cnt
    );

endinterface

// File: rtl/layer_ctrl_mod_counter.sv
// Modulo-MOD up counter with synchronous clear and a terminal-count flag.
module mod_counter #(
    parameter int MOD = 4,
    parameter int W   = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt,
    output logic         wrap
);

    localparam logic [W-1:0] LAST = W'(MOD - 1);

    assign wrap = (cnt == LAST);

    // Count up on inc, folding back to zero after the terminal value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= wrap ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/layer_ctrl.sv
// layer_ctrl: sequencing controller for one fully-connected layer.
// Collects N inputs, then for each of M rows issues N weight/input reads,
// drives accumulator clear/enable, latches the row result and holds it on
// a valid/ready output until accepted.
// Optional build macro LAYER_CTRL_STALL_CNT_EN adds a saturating counter of
// cycles where the output is valid but not accepted; without it stall_cnt is 0.
module layer_ctrl
    import layer_ctrl_pkg::*;
#(
    parameter int M = 4,
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         reset,
    layer_ctrl_if.master bus
);

    localparam int AW_X = addr_width(N);
    localparam int AW_W = addr_width(M * N);
    localparam int RW   = addr_width(M);

    state_t          state;
    state_t          state_nxt;
    logic [AW_X-1:0] k;
    logic            k_wrap;
    logic            k_inc;
    logic [RW-1:0]   row;
    logic            row_wrap;
    logic            row_inc;
    logic            row_clr;
    logic [AW_W-1:0] w_ptr;
    logic            mac_en_q;

    mod_counter #(.MOD(N), .W(AW_X)) u_k_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (k_inc),
        .clr   (1'b0),
        .cnt   (k),
        .wrap  (k_wrap)
    );

    mod_counter #(.MOD(M), .W(RW)) u_row_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (row_inc),
        .clr   (row_clr),
        .cnt   (row),
        .wrap  (row_wrap)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, counter steps and output decode from the current state.
    always_comb begin
        state_nxt   = state;
        k_inc       = 1'b0;
        row_inc     = 1'b0;
        row_clr     = 1'b0;
        bus.s_ready = 1'b0;
        bus.x_wr_en = 1'b0;
        bus.m_valid = 1'b0;
        bus.m_last  = 1'b0;
        bus.mac_clr = 1'b0;
        bus.y_load  = 1'b0;
        case (state)
            LOAD: begin
                bus.s_ready = 1'b1;
                bus.x_wr_en = bus.s_valid;
                if (bus.s_valid) begin
                    k_inc = 1'b1;
                    if (k_wrap) begin
                        row_clr   = 1'b1;
                        state_nxt = ADDR;
                    end
                end
            end
            ADDR: begin
                bus.mac_clr = (k == '0);
                k_inc       = 1'b1;
                if (k_wrap) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                state_nxt = LATCH;
            end
            LATCH: begin
                bus.y_load = 1'b1;
                state_nxt  = OUT;
            end
            OUT: begin
                bus.m_valid = 1'b1;
                bus.m_last  = row_wrap;
                if (bus.m_ready) begin
                    row_inc   = 1'b1;
                    state_nxt = row_wrap ? LOAD : ADDR;
                end
            end
            default: begin
                state_nxt = LOAD;
            end
        endcase
    end

    // Weight pointer tracks row*N+k: restarts while loading, steps each ADDR cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w_ptr <= '0;
        end else if (state == LOAD) begin
            w_ptr <= '0;
        end else if (state == ADDR) begin
            w_ptr <= w_ptr + 1'b1;
        end
    end

    // Accumulate one cycle after each address, matching the one-cycle memory read.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mac_en_q <= 1'b0;
        end else begin
            mac_en_q <= (state == ADDR);
        end
    end

    assign bus.x_addr = k;
    assign bus.w_addr = w_ptr;
    assign bus.mac_en = mac_en_q;

`ifdef LAYER_CTRL_STALL_CNT_EN
    logic [STALL_W-1:0] stall_q;

    // Count cycles where a valid result waits on downstream, saturating.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_q <= '0;
        end else if ((state == OUT) && !bus.m_ready && (stall_q != '1)) begin
            stall_q <= stall_q + 1'b1;
        end
    end

    assign bus.stall_cnt = stall_q;
`else
    assign bus.stall_cnt = '0;
`endif

endmodule

// File: tb/tb_layer_ctrl.sv
// Scoreboard bench for layer_ctrl: M=4,N=4 main instance plus an M=1,N=1 instance.
module tb_layer_ctrl;
    import layer_ctrl_pkg::*;

    localparam int M_T = 4;
    localparam int N_T = 4;

    logic clk;
    logic reset;

    layer_ctrl_if #(.M(M_T), .N(N_T)) bus ();
    layer_ctrl_if #(.M(1), .N(1))     bus1 ();

    layer_ctrl #(.M(M_T), .N(N_T)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    layer_ctrl #(.M(1), .N(1)) u_dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_checks = 0;
    int n_pass   = 0;

    int exp_wr[$];
    int exp_out[$];
    int exp_lat[$];

    int out_count = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic int pending();
        return exp_wr.size() + exp_out.size() + exp_lat.size();
    endfunction

    task automatic push_vector();
        for (int i = 0; i < N_T; i++) exp_wr.push_back(i);
        for (int r = 0; r < M_T; r++) begin
            exp_out.push_back((r == M_T - 1) ? 1 : 0);
            exp_lat.push_back(N_T + 3);
        end
    endtask

    task automatic feed_vector();
        for (int i = 0; i < N_T; i++) begin
            bus.s_valid = 1'b1;
            @(posedge clk); #1;
        end
        bus.s_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int t = 0;
        while (pending() != 0 && t < budget) begin
            @(posedge clk); #1;
            t++;
        end
        chk(name, pending(), 0);
    endtask

    // Monitor model state
    int  wr_seen    = 0;
    int  ref_cyc    = 0;
    int  row_idx    = 0;
    int  addr_next  = 0;
    int  addr_left  = 0;
    int  men_cnt    = 0;
    int  clr_cyc    = 0;
    int  last_men   = 0;
    bit  prev_valid = 0;
    bit  prev_ready = 0;

    always @(negedge clk) begin
        if (reset) begin
            wr_seen = 0; row_idx = 0; addr_left = 0; men_cnt = 0;
            prev_valid = 0; prev_ready = 0;
        end else begin
            if (bus.x_wr_en) begin
                chk("wr_s_ready", bus.s_ready, 1);
                chk("wr_expected", exp_wr.size() != 0, 1);
                if (exp_wr.size() != 0) chk("wr_x_addr", bus.x_addr, exp_wr.pop_front());
                wr_seen++;
                if (wr_seen == N_T) begin
                    wr_seen = 0;
                    ref_cyc = cyc;
                end
            end
            if (bus.m_valid && !prev_valid) begin
                chk("lat_expected", exp_lat.size() != 0, 1);
                if (exp_lat.size() != 0) chk("valid_latency", cyc - ref_cyc, exp_lat.pop_front());
            end
            if (prev_valid && !prev_ready) chk("valid_hold", bus.m_valid, 1);
            if (bus.m_valid)
                chk("out_quiet", {bus.mac_clr, bus.mac_en, bus.y_load, bus.x_wr_en}, 0);
            if (bus.m_valid && bus.m_ready) begin
                chk("out_expected", exp_out.size() != 0, 1);
                if (exp_out.size() != 0) chk("m_last", bus.m_last, exp_out.pop_front());
                ref_cyc = cyc;
                row_idx = (row_idx + 1) % M_T;
                out_count++;
            end
            if (bus.mac_clr) begin
                chk("clr_vs_en", bus.mac_en, 0);
                chk("clr_w_addr", bus.w_addr, row_idx * N_T);
                addr_next = row_idx * N_T + 1;
                addr_left = N_T - 1;
                men_cnt   = 0;
                clr_cyc   = cyc;
            end else if (addr_left > 0) begin
                chk("w_addr_seq", bus.w_addr, addr_next);
                addr_next++;
                addr_left--;
            end
            if (bus.mac_en) begin
                men_cnt++;
                if (men_cnt == 1) chk("mac_en_lag", cyc - clr_cyc, 1);
                last_men = cyc;
            end
            if (bus.y_load) begin
                chk("mac_en_pulses", men_cnt, N_T);
                chk("y_load_after_en", cyc - last_men, 1);
            end
            prev_valid = bus.m_valid;
            prev_ready = bus.m_ready;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int start;
        int clr1, en1, vat1;
        longint exp_stall;
        bus.s_valid  = 1'b0;
        bus.m_ready  = 1'b1;
        bus1.s_valid = 1'b0;
        bus1.m_ready = 1'b1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        // Reset state
        chk("rst_s_ready", bus.s_ready, 1);
        chk("rst_m_valid", bus.m_valid, 0);
        chk("rst_m_last", bus.m_last, 0);
        chk("rst_mac", {bus.mac_clr, bus.mac_en, bus.y_load, bus.x_wr_en}, 0);
        chk("rst_addr", {bus.x_addr, bus.w_addr}, 0);
        chk("rst_stall", bus.stall_cnt, 0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Back-to-back vector, downstream always ready
        push_vector();
        feed_vector();
        wait_drain("drain_basic", 200);

        // Stall first row for 10 cycles
        push_vector();
        bus.m_ready = 1'b0;
        feed_vector();
        t = 0;
        while (!bus.m_valid && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        chk("stall_valid_seen", bus.m_valid, 1);
        repeat (10) begin
            @(posedge clk); #1;
        end
        chk("stall_valid_held", bus.m_valid, 1);
        bus.m_ready = 1'b1;
        wait_drain("drain_stall", 200);
`ifdef LAYER_CTRL_STALL_CNT_EN
        exp_stall = 10;
`else
        exp_stall = 0;
`endif
        chk("stall_cnt", bus.stall_cnt, exp_stall);

        // Reset in the middle of row 1 addressing
        push_vector();
        feed_vector();
        start = out_count;
        t = 0;
        while (out_count == start && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        chk("rst_test_row0_out", out_count - start, 1);
        @(posedge clk); #1;
        chk("pre_reset_mac_en", bus.mac_en, 1);
        #2;
        reset = 1'b1;
        #1;
        chk("midrst_s_ready", bus.s_ready, 1);
        chk("midrst_m_valid", bus.m_valid, 0);
        chk("midrst_mac_en", bus.mac_en, 0);
        chk("midrst_stall", bus.stall_cnt, 0);
        exp_wr.delete();
        exp_out.delete();
        exp_lat.delete();
        @(negedge clk);
        @(posedge clk); #1;
        reset = 1'b0;
        push_vector();
        feed_vector();
        wait_drain("drain_after_reset", 200);

        // Random input/output pacing over 100 vectors
        for (int v = 0; v < 100; v++) push_vector();
        t = 0;
        while (pending() != 0 && t < 20000) begin
            bus.s_valid = 1'($urandom_range(0, 1));
            bus.m_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
            t++;
        end
        bus.s_valid = 1'b0;
        bus.m_ready = 1'b1;
        chk("drain_random", pending(), 0);

        // Degenerate M=1,N=1 instance
        bus1.m_ready = 1'b0;
        bus1.s_valid = 1'b1;
        @(posedge clk); #1;
        bus1.s_valid = 1'b0;
        clr1 = 0; en1 = 0; vat1 = 0;
        for (int i = 1; i <= 8; i++) begin
            if (bus1.mac_clr) clr1++;
            if (bus1.mac_en) en1++;
            if (bus1.m_valid && vat1 == 0) begin
                vat1 = i;
                chk("n1_m_last", bus1.m_last, 1);
            end
            @(posedge clk); #1;
        end
        chk("n1_mac_clr_count", clr1, 1);
        chk("n1_mac_en_count", en1, 1);
        chk("n1_valid_latency", vat1, 4);
        chk("n1_valid_held", bus1.m_valid, 1);
        bus1.m_ready = 1'b1;
        @(posedge clk); #1;
        chk("n1_s_ready_back", bus1.s_ready, 1);
        chk("n1_m_valid_drop", bus1.m_valid, 0);
`ifdef LAYER_CTRL_STALL_CNT_EN
        exp_stall = 5;
`else
        exp_stall = 0;
`endif
        chk("n1_stall_cnt", bus1.stall_cnt, exp_stall);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/layer_ctrl.md
# layer_ctrl

Sequencing controller for one fully-connected layer datapath (M outputs, N inputs, T-bit fixed point). It accepts an N-value input vector over a valid/ready stream, then drives the weight/input memory addresses, accumulator clear/enable and output-register load for each of the M rows. It owns the output valid/ready handshake and repeats this sequence for every vector. The datapath (memories, MAC, output register) sits beside it and carries all data; the controller carries only control.

## Interface
- M, 4, output neurons (rows), ≥1
- N, 4, inputs per vector, ≥1
- AW_X, $clog2(N) (min 1), x_addr width (derived)
- AW_W, $clog2(M*N) (min 1), w_addr width (derived)
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high
- s_valid  in  1  input value present
- s_ready  out  1  controller accepts an input value
- m_ready  in  1  downstream accepts output
- m_valid  out  1  output register holds a valid row result
- m_last  out  1  qualifies m_valid for row M-1
- x_wr_en  out  1  write data_in to input memory at x_addr
- x_addr  out  AW_X  input memory address (write in LOAD, read in ADDR)
- w_addr  out  AW_W  weight memory read address, row*N+k
- mac_clr  out  1  clear accumulator
- mac_en  out  1  accumulate current memory outputs
- y_load  out  1  latch accumulator into output register
- stall_cnt  out  32  output stall counter (see Configuration)

## Operation
- States: LOAD, ADDR, DRAIN, LATCH, OUT. Counters k (0..N-1), row (0..M-1).
- LOAD: s_ready=1; x_wr_en = s_valid&&s_ready (combinational); x_addr=k. Each handshake increments k; handshake with k=N-1 -> k=0, row=0, go ADDR.
- ADDR: x_addr=k, w_addr=row*N+k; mac_clr=1 when k=0; k increments every cycle; k=N-1 -> k=0, go DRAIN.
- mac_en is the registered "address issued" flag (memory read latency exactly 1): high in ADDR k≥1 and in DRAIN; N pulses per row, never coincident with mac_clr.
- DRAIN -> LATCH. LATCH: y_load=1, go OUT.
- OUT: m_valid=1, m_last=(row==M-1). On m_valid&&m_ready: if row<M-1 then row++, go ADDR; else go LOAD.
- s_ready=0 outside LOAD; s_valid ignored there. m_ready ignored outside OUT.
- Reset (any time, including mid-row): state LOAD, k=0, row=0; all outputs 0 except s_ready=1 (LOAD); stall_cnt=0.

## Timing
- Handshake edges are rising edges with both signals high.
- Last input accepted at edge E: ADDR occupies the N cycles after E, DRAIN cycle E+N+1, LATCH E+N+2, m_valid high from cycle E+N+3 and held until accepted.
- Output accepted at edge F with more rows pending: ADDR starts cycle after F; next m_valid N+3 cycles after F. Minimum period per row N+3 cycles, per vector N + M*(N+3).
- After the last row is accepted, s_ready rises the following cycle; no input is accepted in the same cycle as an output.
- m_valid never drops without a handshake; controller outputs are registered except s_ready-derived x_wr_en.

## Configuration
- LAYER_CTRL_STALL_CNT_EN defined: stall_cnt increments (saturating at 2^32-1) each cycle with m_valid=1 and m_ready=0; cleared only by reset.
- Undefined: stall_cnt tied to 0, no counter flops.

## Structure
- Package layer_ctrl_pkg: state enum (LOAD, ADDR, DRAIN, LATCH, OUT), address-width helper function with min-1 rule.
- One sub-module: mod_counter (parameterised modulus, inc/clear, wrap flag), instantiated for k and row.

## Test plan
- M=4,N=4, inputs back-to-back, m_ready=1 -> 4 x_wr_en at x_addr 0..3; m_valid first high 7 cycles after the 4th handshake; m_last only on 4th output.
- Same, row 2 -> w_addr 8,9,10,11 in consecutive cycles; mac_clr with w_addr 8; mac_en 4 cycles, lagging one cycle; y_load one cycle after last mac_en.
- m_ready held 0 for 10 cycles in OUT -> m_valid stays 1, no address activity; with LAYER_CTRL_STALL_CNT_EN stall_cnt=10.
- s_valid toggling randomly, s_valid=1 during ADDR/OUT -> no x_wr_en outside LOAD; exactly 4 writes per vector, 4 outputs per vector over 100 vectors.
- reset asserted mid-ADDR of row 1 -> immediately s_ready=1, m_valid=0, mac_en=0; next 4 inputs written at x_addr 0..3.
- M=1,N=1 -> x_addr width 1; one mac_clr, one mac_en, m_valid with m_last=1, 4 cycles after input.
